// File: rtl/spi_mem_responder.sv
// SPI mode-0 target bridging SRAM-style READ (0x03) / WRITE (0x02) frames onto a
// single-outstanding byte bus. SPI pins are oversampled in the clk domain.
module spi_mem_responder #(
  parameter int SYNC_STAGES     = 2,
  parameter int READ_DUMMY_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        cmd_err,
  output logic        xfer_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [3:0] DUMMY_LAST = 4'(READ_DUMMY_BITS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic        sclk_d, cs_d;
  logic        sclk_s, mosi_s, cs_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_shift, tx_shift, pf_data;
  logic [7:0]  rx_byte;
  logic [15:0] addr, addr_next;
  logic        pf_valid, is_read, byte_start, start_pending;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign rx_byte   = {rx_shift[6:0], mosi_s};
  assign addr_next = {addr[14:0], mosi_s};
  assign spi_miso  = tx_shift[7];
  assign busy      = (state != IDLE) | mem_req;

  // Synchronisers park at the idle bus levels so reset release never looks like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      pf_data       <= '0;
      pf_valid      <= 1'b0;
      addr          <= '0;
      is_read       <= 1'b0;
      byte_start    <= 1'b0;
      start_pending <= 1'b0;
      spi_miso_oe   <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cmd_err       <= 1'b0;
      xfer_err      <= 1'b0;
    end else begin
      cmd_err  <= 1'b0;
      xfer_err <= 1'b0;

      // Read data is only kept while the read frame that asked for it is still open
      if (mem_req && mem_ready) begin
        mem_req <= 1'b0;
        if (mem_we) begin
          addr <= addr + 16'd1;
        end else if (state == DUMMY || state == RD_DATA) begin
          pf_data  <= mem_rdata;
          pf_valid <= 1'b1;
        end
      end

      if (cs_rise) begin
        state         <= IDLE;
        spi_miso_oe   <= 1'b0;
        bit_cnt       <= '0;
        byte_start    <= 1'b0;
        start_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if ((cs_fall || start_pending) && !mem_req) begin
              state         <= CMD;
              bit_cnt       <= '0;
              rx_shift      <= '0;
              pf_valid      <= 1'b0;
              start_pending <= 1'b0;
            end else if (cs_fall) begin
              start_pending <= 1'b1;
            end
          end
          CMD: if (sclk_rise) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              case (rx_byte)
                CMD_READ:  begin is_read <= 1'b1; state <= ADDR; end
                CMD_WRITE: begin is_read <= 1'b0; state <= ADDR; end
                default:   begin state <= IGNORE; cmd_err <= 1'b1; end
              endcase
            end
          end
          ADDR: if (sclk_rise) begin
            addr    <= addr_next;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              bit_cnt  <= '0;
              rx_shift <= '0;
              if (is_read) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= addr_next;
                if (READ_DUMMY_BITS == 0) begin
                  state       <= RD_DATA;
                  spi_miso_oe <= 1'b1;
                  byte_start  <= 1'b1;
                end else begin
                  state <= DUMMY;
                end
              end else begin
                state <= WR_DATA;
              end
            end
          end
          DUMMY: if (sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == DUMMY_LAST) begin
              bit_cnt     <= '0;
              state       <= RD_DATA;
              spi_miso_oe <= 1'b1;
              byte_start  <= 1'b1;
            end
          end
          // A byte boundary reloads from the prefetch and launches the next fetch
          RD_DATA: begin
            if (sclk_rise) begin
              if (bit_cnt == 4'd7) begin
                bit_cnt    <= '0;
                byte_start <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (sclk_fall) begin
              if (byte_start) begin
                byte_start <= 1'b0;
                if (pf_valid) begin
                  tx_shift <= pf_data;
                  pf_valid <= 1'b0;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= addr + 16'd1;
                  addr     <= addr + 16'd1;
                end else begin
                  tx_shift <= 8'hFF;
                  xfer_err <= 1'b1;
                end
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          WR_DATA: if (sclk_rise) begin
            rx_shift <= rx_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (mem_req) begin
                xfer_err <= 1'b1;
              end else begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= rx_byte;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
